// File: rtl/aes_axil_pkg.sv
// Shared constants and FSM state types for the AES AXI4-Lite register block.
// Byte-strobe merging is only used when AES_AXIL_WSTRB_EN is defined.
package aes_axil_pkg;

    localparam logic [5:0] OFF_DIN0   = 6'h00;
    localparam logic [5:0] OFF_DIN1   = 6'h04;
    localparam logic [5:0] OFF_DIN2   = 6'h08;
    localparam logic [5:0] OFF_DIN3   = 6'h0C;
    localparam logic [5:0] OFF_KEY0   = 6'h10;
    localparam logic [5:0] OFF_KEY1   = 6'h14;
    localparam logic [5:0] OFF_KEY2   = 6'h18;
    localparam logic [5:0] OFF_KEY3   = 6'h1C;
    localparam logic [5:0] OFF_CTRL   = 6'h20;
    localparam logic [5:0] OFF_STATUS = 6'h24;
    localparam logic [5:0] OFF_DOUT0  = 6'h28;
    localparam logic [5:0] OFF_DOUT1  = 6'h2C;
    localparam logic [5:0] OFF_DOUT2  = 6'h30;
    localparam logic [5:0] OFF_DOUT3  = 6'h34;
    localparam logic [5:0] OFF_LIMIT  = 6'h38;

    localparam int CTRL_START   = 0;
    localparam int CTRL_DECRYPT = 1;
    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_OVERRUN   = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_e;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

endpackage

// File: rtl/aes_axil_wr_fsm.sv
// AW/W/B handshake: accepts address and data in either order, then issues
// a one-cycle write strobe and holds the B response until BREADY.
module aes_axil_wr_fsm
    import aes_axil_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic [3:0]        wstrb_o
);

    wr_state_e         state_q, state_d;
    logic              init_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        strb_q, strb_d;
    logic [1:0]        resp_q, resp_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WR_IDLE;
            init_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            resp_q  <= resp_d;
        end
    end

    // init_q keeps both READYs low for the first cycle out of reset
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        resp_d    = resp_q;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        we_o      = 1'b0;
        waddr_o   = awaddr_i;
        wdata_o   = wdata_i;
        wstrb_o   = wstrb_i;
        case (state_q)
            WR_IDLE: begin
                awready_o = init_q;
                wready_o  = init_q;
                if (init_q) begin
                    if (awvalid_i && wvalid_i) begin
                        we_o    = 1'b1;
                        state_d = WR_RESP;
                    end else if (awvalid_i) begin
                        addr_d  = awaddr_i;
                        state_d = WR_WAIT_W;
                    end else if (wvalid_i) begin
                        data_d  = wdata_i;
                        strb_d  = wstrb_i;
                        state_d = WR_WAIT_AW;
                    end
                end
            end
            WR_WAIT_W: begin
                wready_o = 1'b1;
                waddr_o  = addr_q;
                if (wvalid_i) begin
                    we_o    = 1'b1;
                    state_d = WR_RESP;
                end
            end
            WR_WAIT_AW: begin
                awready_o = 1'b1;
                wdata_o   = data_q;
                wstrb_o   = strb_q;
                if (awvalid_i) begin
                    we_o    = 1'b1;
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) state_d = WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase
        if (we_o) resp_d = (waddr_o >= OFF_LIMIT) ? RESP_SLVERR : RESP_OKAY;
    end

    assign bresp_o = resp_q;

endmodule

// File: rtl/aes_axil_regs.sv
// AXI4-Lite register front end for an AES core: DIN/KEY/CTRL/STATUS/DOUT.
// Define AES_AXIL_WSTRB_EN to honour WSTRB; otherwise writes are full-word.
module aes_axil_regs
    import aes_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            S00_AXI_ACLK,
    input  logic                            S00_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S00_AXI_AWADDR,
    input  logic [2:0]                      S00_AXI_AWPROT,
    input  logic                            S00_AXI_AWVALID,
    output logic                            S00_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S00_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S00_AXI_WSTRB,
    input  logic                            S00_AXI_WVALID,
    output logic                            S00_AXI_WREADY,
    output logic [1:0]                      S00_AXI_BRESP,
    output logic                            S00_AXI_BVALID,
    input  logic                            S00_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S00_AXI_ARADDR,
    input  logic [2:0]                      S00_AXI_ARPROT,
    input  logic                            S00_AXI_ARVALID,
    output logic                            S00_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S00_AXI_RDATA,
    output logic [1:0]                      S00_AXI_RRESP,
    output logic                            S00_AXI_RVALID,
    input  logic                            S00_AXI_RREADY,
    output logic                            core_start,
    output logic                            core_decrypt,
    output logic [127:0]                    core_key,
    output logic [127:0]                    core_din,
    input  logic                            core_done,
    input  logic [127:0]                    core_dout
);

    logic                          we;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_addr;
    logic [31:0]                   w_data;
    logic [3:0]                    w_strb;
    logic [31:0]                   wmask;
    logic                          wb0;
    logic [5:0]                    wa, ra;

    aes_axil_wr_fsm #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH)
    ) u_wr_fsm (
        .clk_i     (S00_AXI_ACLK),
        .rst_i     (S00_AXI_ARESET),
        .awaddr_i  (S00_AXI_AWADDR),
        .awvalid_i (S00_AXI_AWVALID),
        .awready_o (S00_AXI_AWREADY),
        .wdata_i   (S00_AXI_WDATA),
        .wstrb_i   (S00_AXI_WSTRB),
        .wvalid_i  (S00_AXI_WVALID),
        .wready_o  (S00_AXI_WREADY),
        .bresp_o   (S00_AXI_BRESP),
        .bvalid_o  (S00_AXI_BVALID),
        .bready_i  (S00_AXI_BREADY),
        .we_o      (we),
        .waddr_o   (w_addr),
        .wdata_o   (w_data),
        .wstrb_o   (w_strb)
    );

`ifdef AES_AXIL_WSTRB_EN
    assign wmask = strb_mask(w_strb);
    assign wb0   = w_strb[0];
`else
    logic unused_strb;
    assign unused_strb = ^w_strb;
    assign wmask = '1;
    assign wb0   = 1'b1;
`endif

    assign wa = {w_addr[5:2], 2'b00};
    assign ra = {S00_AXI_ARADDR[5:2], 2'b00};

    logic unused_bits;
    assign unused_bits = ^{S00_AXI_AWPROT, S00_AXI_ARPROT,
                           S00_AXI_ARADDR[1:0], w_addr[1:0]};

    logic [31:0] din_q [4], din_d [4];
    logic [31:0] key_q [4], key_d [4];
    logic [31:0] dout_q [4], dout_d [4];
    logic        decrypt_q, decrypt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic        start_q, start_d;
    logic        init_q;
    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    always_ff @(posedge S00_AXI_ACLK) begin
        if (S00_AXI_ARESET) begin
            din_q      <= '{default: '0};
            key_q      <= '{default: '0};
            dout_q     <= '{default: '0};
            decrypt_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            start_q    <= 1'b0;
            init_q     <= 1'b0;
            rd_state_q <= RD_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            din_q      <= din_d;
            key_q      <= key_d;
            dout_q     <= dout_d;
            decrypt_q  <= decrypt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            start_q    <= start_d;
            init_q     <= 1'b1;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // W1C clears are applied before core_done so a coincident set wins
    always_comb begin
        din_d     = din_q;
        key_d     = key_q;
        dout_d    = dout_q;
        decrypt_d = decrypt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        start_d   = 1'b0;
        if (we) begin
            case (wa)
                OFF_DIN0, OFF_DIN1, OFF_DIN2, OFF_DIN3:
                    din_d[wa[3:2]] = (din_q[wa[3:2]] & ~wmask) | (w_data & wmask);
                OFF_KEY0, OFF_KEY1, OFF_KEY2, OFF_KEY3:
                    key_d[wa[3:2]] = (key_q[wa[3:2]] & ~wmask) | (w_data & wmask);
                OFF_CTRL: if (wb0) begin
                    decrypt_d = w_data[CTRL_DECRYPT];
                    if (w_data[CTRL_START]) begin
                        if (busy_q) begin
                            ovr_d = 1'b1;
                        end else begin
                            start_d = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                end
                OFF_STATUS: if (wb0) begin
                    if (w_data[ST_DONE]) done_d = 1'b0;
                    if (w_data[ST_OVERRUN]) ovr_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (core_done) begin
            dout_d[0] = core_dout[31:0];
            dout_d[1] = core_dout[63:32];
            dout_d[2] = core_dout[95:64];
            dout_d[3] = core_dout[127:96];
            busy_d    = 1'b0;
            done_d    = 1'b1;
        end
    end

    logic [31:0] rd_word;
    logic        rd_err;

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (ra)
            OFF_DIN0, OFF_DIN1, OFF_DIN2, OFF_DIN3:
                rd_word = din_q[ra[3:2]];
            OFF_KEY0, OFF_KEY1, OFF_KEY2, OFF_KEY3:
                rd_word = key_q[ra[3:2]];
            OFF_CTRL:
                rd_word[CTRL_DECRYPT] = decrypt_q;
            OFF_STATUS: begin
                rd_word[ST_BUSY]    = busy_q;
                rd_word[ST_DONE]    = done_q;
                rd_word[ST_OVERRUN] = ovr_q;
            end
            OFF_DOUT0: rd_word = dout_q[0];
            OFF_DOUT1: rd_word = dout_q[1];
            OFF_DOUT2: rd_word = dout_q[2];
            OFF_DOUT3: rd_word = dout_q[3];
            default:   rd_err  = 1'b1;
        endcase
    end

    always_comb begin
        rd_state_d      = rd_state_q;
        rdata_d         = rdata_q;
        rresp_d         = rresp_q;
        S00_AXI_ARREADY = 1'b0;
        S00_AXI_RVALID  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                S00_AXI_ARREADY = init_q;
                if (init_q && S00_AXI_ARVALID) begin
                    rdata_d    = rd_word;
                    rresp_d    = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                S00_AXI_RVALID = 1'b1;
                if (S00_AXI_RREADY) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign S00_AXI_RDATA = rdata_q;
    assign S00_AXI_RRESP = rresp_q;
    assign core_start    = start_q;
    assign core_decrypt  = decrypt_q;
    assign core_key      = {key_q[3], key_q[2], key_q[1], key_q[0]};
    assign core_din      = {din_q[3], din_q[2], din_q[1], din_q[0]};

endmodule

// File: tb/tb_aes_axil_regs.sv
// Self-checking bench for aes_axil_regs: vector table plus read scoreboard
// and hand-written handshake, status and reset sequences.
module tb_aes_axil_regs;
    import aes_axil_pkg::*;

    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic [5:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b1;
    logic [5:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b1;
    logic         core_start;
    logic         core_decrypt;
    logic [127:0] core_key;
    logic [127:0] core_din;
    logic         core_done = 1'b0;
    logic [127:0] core_dout = '0;

    aes_axil_regs dut (
        .S00_AXI_ACLK    (clk),
        .S00_AXI_ARESET  (arst),
        .S00_AXI_AWADDR  (awaddr),
        .S00_AXI_AWPROT  (awprot),
        .S00_AXI_AWVALID (awvalid),
        .S00_AXI_AWREADY (awready),
        .S00_AXI_WDATA   (wdata),
        .S00_AXI_WSTRB   (wstrb),
        .S00_AXI_WVALID  (wvalid),
        .S00_AXI_WREADY  (wready),
        .S00_AXI_BRESP   (bresp),
        .S00_AXI_BVALID  (bvalid),
        .S00_AXI_BREADY  (bready),
        .S00_AXI_ARADDR  (araddr),
        .S00_AXI_ARPROT  (arprot),
        .S00_AXI_ARVALID (arvalid),
        .S00_AXI_ARREADY (arready),
        .S00_AXI_RDATA   (rdata),
        .S00_AXI_RRESP   (rresp),
        .S00_AXI_RVALID  (rvalid),
        .S00_AXI_RREADY  (rready),
        .core_start      (core_start),
        .core_decrypt    (core_decrypt),
        .core_key        (core_key),
        .core_din        (core_din),
        .core_done       (core_done),
        .core_dout       (core_dout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    always @(negedge clk) if (core_start) start_cnt++;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } rexp_t;
    rexp_t rq[$];

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } vec_t;
    vec_t vecs[21];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] er,
                            input string nm);
        bit aw_ok = 0;
        bit w_ok = 0;
        int n = 0;
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (!(aw_ok && w_ok) && n < 20) begin
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            tick();
            n++;
            if (aw_ok) awvalid = 1'b0;
            if (w_ok) wvalid = 1'b0;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " bvalid"}, bvalid, 1'b1);
        chk({nm, " bresp"}, bresp, er);
        tick();
    endtask

    task automatic do_read(input logic [5:0] a, input logic [31:0] d,
                           input logic [1:0] er, input string nm);
        rexp_t e;
        bit ar_ok = 0;
        int n = 0;
        rq.push_back('{d, er, nm});
        araddr = a; arvalid = 1'b1;
        while (!ar_ok && n < 20) begin
            if (arready) ar_ok = 1;
            tick();
            n++;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        e = rq.pop_front();
        chk({e.name, " rvalid"}, rvalid, 1'b1);
        chk({e.name, " rdata"}, rdata, e.data);
        chk({e.name, " rresp"}, rresp, e.resp);
        tick();
    endtask

    task automatic pulse_done(input logic [127:0] v);
        core_done = 1'b1;
        core_dout = v;
        tick();
        core_done = 1'b0;
    endtask

    initial begin
        rexp_t e;
        int base;
        int n;
        logic [31:0] strb_exp;

        vecs[0]  = '{1, OFF_DIN0, 32'h1, RESP_OKAY, "wr din0"};
        vecs[1]  = '{1, OFF_DIN1, 32'h2, RESP_OKAY, "wr din1"};
        vecs[2]  = '{1, OFF_DIN2, 32'h3, RESP_OKAY, "wr din2"};
        vecs[3]  = '{1, OFF_DIN3, 32'h4, RESP_OKAY, "wr din3"};
        vecs[4]  = '{0, OFF_DIN0, 32'h1, RESP_OKAY, "rd din0"};
        vecs[5]  = '{0, OFF_DIN1, 32'h2, RESP_OKAY, "rd din1"};
        vecs[6]  = '{0, OFF_DIN2, 32'h3, RESP_OKAY, "rd din2"};
        vecs[7]  = '{0, OFF_DIN3, 32'h4, RESP_OKAY, "rd din3"};
        vecs[8]  = '{1, OFF_KEY0, 32'h11111111, RESP_OKAY, "wr key0"};
        vecs[9]  = '{1, OFF_KEY1, 32'h22222222, RESP_OKAY, "wr key1"};
        vecs[10] = '{1, OFF_KEY2, 32'h33333333, RESP_OKAY, "wr key2"};
        vecs[11] = '{1, OFF_KEY3, 32'h44444444, RESP_OKAY, "wr key3"};
        vecs[12] = '{0, OFF_KEY3, 32'h44444444, RESP_OKAY, "rd key3"};
        vecs[13] = '{0, OFF_CTRL, 32'h0, RESP_OKAY, "rd ctrl"};
        vecs[14] = '{0, OFF_STATUS, 32'h0, RESP_OKAY, "rd status"};
        vecs[15] = '{0, OFF_DOUT0, 32'h0, RESP_OKAY, "rd dout0"};
        vecs[16] = '{1, 6'h38, 32'h12345678, RESP_SLVERR, "wr 0x38"};
        vecs[17] = '{0, 6'h3C, 32'h0, RESP_SLVERR, "rd 0x3c"};
        vecs[18] = '{0, OFF_DIN0, 32'h1, RESP_OKAY, "rd din0 after err"};
        vecs[19] = '{1, OFF_DOUT0, 32'hFFFFFFFF, RESP_OKAY, "wr dout0 ro"};
        vecs[20] = '{0, OFF_DOUT0, 32'h0, RESP_OKAY, "rd dout0 ro"};

        repeat (3) tick();
        arst = 1'b0;
        chk("rst awready", awready, 1'b0);
        chk("rst wready", wready, 1'b0);
        chk("rst arready", arready, 1'b0);
        chk("rst bvalid", bvalid, 1'b0);
        chk("rst rvalid", rvalid, 1'b0);
        chk("rst core_start", core_start, 1'b0);
        tick();
        chk("idle awready", awready, 1'b1);
        chk("idle wready", wready, 1'b1);
        chk("idle arready", arready, 1'b1);

        foreach (vecs[i]) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].data, 4'hF, vecs[i].resp,
                         vecs[i].name);
            else
                do_read(vecs[i].addr, vecs[i].data, vecs[i].resp,
                        vecs[i].name);
        end
        chk("core_din", core_din,
            128'h00000004_00000003_00000002_00000001);
        chk("core_key", core_key,
            128'h44444444_33333333_22222222_11111111);

        // write and read of DIN0 in the same cycle
        rq.push_back('{32'h1, RESP_OKAY, "same-cycle rd"});
        awaddr = OFF_DIN0; wdata = 32'hDEAD0000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = OFF_DIN0; arvalid = 1'b1;
        chk("same-cycle readys", {awready, wready, arready}, 3'b111);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        e = rq.pop_front();
        chk({e.name, " rvalid"}, rvalid, 1'b1);
        chk({e.name, " rdata"}, rdata, e.data);
        chk("same-cycle bvalid", bvalid, 1'b1);
        tick();
        do_read(OFF_DIN0, 32'hDEAD0000, RESP_OKAY, "rd din0 new");

        // AW first, W three cycles later, BREADY held low
        bready = 1'b0;
        awaddr = OFF_DIN1; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("wait_w awready", awready, 1'b0);
        chk("wait_w wready", wready, 1'b1);
        tick();
        tick();
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("split bvalid c4", bvalid, 1'b1);
        chk("split wready low", wready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bvalid hold", bvalid, 1'b1);
        end
        bready = 1'b1;
        tick();
        chk("bvalid drop", bvalid, 1'b0);
        do_read(OFF_DIN1, 32'h55, RESP_OKAY, "rd din1 split");

        // W first, then AW
        wdata = 32'h66; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("wait_aw awready", awready, 1'b1);
        chk("wait_aw wready", wready, 1'b0);
        tick();
        awaddr = OFF_DIN2; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("w-first bvalid", bvalid, 1'b1);
        tick();
        do_read(OFF_DIN2, 32'h66, RESP_OKAY, "rd din2 w-first");

        // start, completion and W1C
        base = start_cnt;
        do_write(OFF_CTRL, 32'h1, 4'hF, RESP_OKAY, "wr start");
        chk("start pulses", start_cnt - base, 1);
        do_read(OFF_STATUS, 32'h1, RESP_OKAY, "rd status busy");
        do_read(OFF_CTRL, 32'h0, RESP_OKAY, "rd ctrl start=0");
        pulse_done(128'h00112233_44556677_8899AABB_CCDDEEFF);
        do_read(OFF_STATUS, 32'h2, RESP_OKAY, "rd status done");
        do_read(OFF_DOUT0, 32'hCCDDEEFF, RESP_OKAY, "rd dout0");
        do_read(OFF_DOUT3, 32'h00112233, RESP_OKAY, "rd dout3");
        do_write(OFF_STATUS, 32'h2, 4'hF, RESP_OKAY, "w1c done");
        do_read(OFF_STATUS, 32'h0, RESP_OKAY, "rd status cleared");

        // start while busy
        base = start_cnt;
        do_write(OFF_CTRL, 32'h1, 4'hF, RESP_OKAY, "wr start a");
        do_write(OFF_CTRL, 32'h1, 4'hF, RESP_OKAY, "wr start b");
        do_read(OFF_STATUS, 32'h5, RESP_OKAY, "rd status overrun");
        chk("overrun one pulse", start_cnt - base, 1);
        do_write(OFF_STATUS, 32'h4, 4'hF, RESP_OKAY, "w1c overrun");
        do_read(OFF_STATUS, 32'h1, RESP_OKAY, "rd status ovr clr");
        pulse_done(128'h1);
        do_read(OFF_STATUS, 32'h2, RESP_OKAY, "rd status done2");
        do_write(OFF_STATUS, 32'h2, 4'hF, RESP_OKAY, "w1c done2");

        // W1C of DONE coinciding with core_done
        awaddr = OFF_STATUS; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        core_done = 1'b1; core_dout = 128'h2;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; core_done = 1'b0;
        chk("set-wins bvalid", bvalid, 1'b1);
        tick();
        do_read(OFF_STATUS, 32'h2, RESP_OKAY, "rd status set wins");
        do_write(OFF_STATUS, 32'h6, 4'hF, RESP_OKAY, "w1c all");

        // decrypt bit without start
        base = start_cnt;
        do_write(OFF_CTRL, 32'h2, 4'hF, RESP_OKAY, "wr decrypt");
        chk("core_decrypt", core_decrypt, 1'b1);
        do_read(OFF_CTRL, 32'h2, RESP_OKAY, "rd ctrl decrypt");
        chk("decrypt no start", start_cnt - base, 0);
        do_read(OFF_STATUS, 32'h0, RESP_OKAY, "rd status idle");

        // byte strobes
        do_write(OFF_KEY0, 32'h0, 4'hF, RESP_OKAY, "wr key0 zero");
        do_write(OFF_KEY0, 32'hAABBCCDD, 4'b0101, RESP_OKAY, "wr key0 strb");
`ifdef AES_AXIL_WSTRB_EN
        strb_exp = 32'h00BB00DD;
`else
        strb_exp = 32'hAABBCCDD;
`endif
        do_read(OFF_KEY0, strb_exp, RESP_OKAY, "rd key0 strb");

        // reset in the middle of a write
        awaddr = OFF_DIN3; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("mid wait_w wready", wready, 1'b1);
        arst = 1'b1;
        tick();
        tick();
        arst = 1'b0;
        chk("mid rst bvalid", bvalid, 1'b0);
        chk("mid rst awready", awready, 1'b0);
        tick();
        chk("mid idle readys", {awready, wready}, 2'b11);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid) n++;
            tick();
        end
        chk("mid no bresp", n, 0);
        do_read(OFF_DIN0, 32'h0, RESP_OKAY, "rd din0 after rst");
        do_read(OFF_KEY1, 32'h0, RESP_OKAY, "rd key1 after rst");
        chk("core_decrypt after rst", core_decrypt, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
